// File: rtl/servo_pwm_rx.sv
`default_nettype none
// ============================================================================
// Module   : servo_pwm_rx
// Brief    : Servo PWM receiver; measures pulse high time and decodes it to
//            the 8-bit servo position code, with error and loss-of-signal flags.
// Revision : 1.0 - initial release
// ============================================================================

module servo_pwm_rx #(
    parameter int unsigned T_MIN    = 12000,
    parameter int unsigned T_STEP   = 47,
    parameter int unsigned T_GLITCH = 6000,
    parameter int unsigned T_MAXP   = 36000,
    parameter int unsigned T_LOST   = 480000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       srv_i,
    output logic [7:0] pos,
    output logic       pos_vld,
    output logic       err,
    output logic       lost
);

    localparam int unsigned     c_cw          = 20;
    localparam logic [c_cw-1:0] c_cnt_max     = '1;
    localparam logic [c_cw-1:0] c_t_min       = c_cw'(T_MIN);
    localparam logic [c_cw-1:0] c_t_step_m1   = c_cw'(T_STEP - 1);
    localparam logic [c_cw-1:0] c_t_glitch    = c_cw'(T_GLITCH);
    localparam logic [c_cw-1:0] c_t_maxp      = c_cw'(T_MAXP);
    localparam logic [c_cw-1:0] c_t_lost      = c_cw'(T_LOST);
    localparam logic [c_cw-1:0] c_t_lost_m1   = c_cw'(T_LOST - 1);

    typedef enum logic [1:0] {
        S_ARM  = 2'd0,
        S_IDLE = 2'd1,
        S_HIGH = 2'd2
    } state_t;

    state_t          r_state;
    logic            r_sync1;
    logic            r_sync2;
    logic            r_prev;
    logic [1:0]      r_fill;
    logic [c_cw-1:0] r_h;
    logic [c_cw-1:0] r_pre;
    logic [7:0]      r_step;
    logic [c_cw-1:0] r_loss;

    logic            w_level;
    logic            w_rise;
    logic            w_sync_ok;
    logic            w_overlong;
    logic            w_accept;

    // r_fill marks when r_sync2 reflects a real pin sample rather than the
    // reset value, so ARM cannot mistake reset zeros for a genuine low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
            r_fill  <= 2'b00;
        end else begin
            r_sync1 <= srv_i;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_fill  <= {r_fill[0], 1'b1};
        end
    end

    assign w_level    = r_sync2;
    assign w_rise     = r_sync2 & ~r_prev;
    assign w_sync_ok  = r_fill[1];
    assign w_overlong = (r_h > c_t_maxp);
    assign w_accept   = (r_state == S_HIGH) && !w_overlong && !w_level &&
                        (r_h >= c_t_glitch);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_ARM;
            r_h     <= '0;
            r_pre   <= '0;
            r_step  <= 8'h00;
            pos     <= 8'h00;
            pos_vld <= 1'b0;
            err     <= 1'b0;
        end else begin
            pos_vld <= 1'b0;
            err     <= 1'b0;
            case (r_state)
                S_ARM: begin
                    if (w_sync_ok && !w_level) begin
                        r_state <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (w_rise) begin
                        r_h     <= c_cw'(1);
                        r_pre   <= '0;
                        r_step  <= 8'h00;
                        r_state <= S_HIGH;
                    end
                end
                S_HIGH: begin
                    if (w_overlong) begin
                        // A fall coinciding with the overlong error goes straight
                        // to IDLE so a rise on the next cycle is still caught.
                        err     <= 1'b1;
                        r_state <= w_level ? S_ARM : S_IDLE;
                    end else if (!w_level) begin
                        if (w_accept) begin
                            pos     <= r_step;
                            pos_vld <= 1'b1;
                        end else begin
                            err     <= 1'b1;
                        end
                        r_state <= S_IDLE;
                    end else begin
                        if (r_h != c_cnt_max) begin
                            r_h <= r_h + c_cw'(1);
                        end
                        // Position = floor((h - T_MIN) / T_STEP), built up
                        // incrementally as h grows past T_MIN.
                        if (r_h >= c_t_min) begin
                            if (r_pre >= c_t_step_m1) begin
                                r_pre <= '0;
                                if (r_step != 8'hFF) begin
                                    r_step <= r_step + 8'd1;
                                end
                            end else begin
                                r_pre <= r_pre + c_cw'(1);
                            end
                        end
                    end
                end
                default: begin
                    r_state <= S_ARM;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_loss <= '0;
            lost   <= 1'b1;
        end else if (w_accept) begin
            r_loss <= '0;
            lost   <= 1'b0;
        end else if (r_loss < c_t_lost) begin
            r_loss <= r_loss + c_cw'(1);
            if (r_loss == c_t_lost_m1) begin
                lost <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_servo_pwm_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_servo_pwm_rx
// Brief    : Self-checking bench for servo_pwm_rx using scaled timing parameters.
// Revision : 1.0 - initial release
// ============================================================================

module tb_servo_pwm_rx;

    localparam int T_MIN    = 100;
    localparam int T_STEP   = 2;
    localparam int T_GLITCH = 50;
    localparam int T_MAXP   = 700;
    localparam int T_LOST   = 2000;

    typedef struct packed {
        logic        vld;
        logic [31:0] cyc;
        logic [7:0]  pos;
        logic        lost;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       srv_i = 1'b0;
    logic [7:0] pos;
    logic       pos_vld;
    logic       err;
    logic       lost;

    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] m_pos = 8'h00;
    ev_t        obs_q[$];
    ev_t        exp_q[$];

    servo_pwm_rx #(
        .T_MIN    (T_MIN),
        .T_STEP   (T_STEP),
        .T_GLITCH (T_GLITCH),
        .T_MAXP   (T_MAXP),
        .T_LOST   (T_LOST)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .srv_i   (srv_i),
        .pos     (pos),
        .pos_vld (pos_vld),
        .err     (err),
        .lost    (lost)
    );

    always #5 clk = ~clk;

    // Event recorder: cyc is the index of the clock edge just taken.
    always @(posedge clk) begin
        ev_t e;
        #1;
        cyc = cyc + 1;
        if (pos_vld) begin
            e.vld = 1'b1; e.cyc = 32'(cyc); e.pos = pos; e.lost = lost;
            obs_q.push_back(e);
        end
        if (err) begin
            e.vld = 1'b0; e.cyc = 32'(cyc); e.pos = pos; e.lost = 1'b0;
            obs_q.push_back(e);
        end
    end

    function automatic logic [7:0] pos_of(input int h);
        int q;
        if (h < T_MIN) return 8'h00;
        q = (h - T_MIN) / T_STEP;
        if (q > 255) q = 255;
        return 8'(q);
    endfunction

    // Drives a pulse of n sampled-high cycles then gap sampled-low cycles,
    // and queues the event the specification predicts for it.
    task automatic pulse(input int n, input int gap);
        int  er;
        ev_t e;
        @(negedge clk);
        srv_i = 1'b1;
        er = cyc + 1;
        repeat (n - 1) @(negedge clk);
        @(negedge clk);
        srv_i = 1'b0;
        repeat (gap - 1) @(negedge clk);
        e.lost = 1'b0;
        if (n > T_MAXP) begin
            e.vld = 1'b0; e.cyc = 32'(er + T_MAXP + 3); e.pos = m_pos;
        end else if (n < T_GLITCH) begin
            e.vld = 1'b0; e.cyc = 32'(er + n + 2); e.pos = m_pos;
        end else begin
            m_pos = pos_of(n);
            e.vld = 1'b1; e.cyc = 32'(er + n + 2); e.pos = m_pos;
        end
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        checks++;
        if ({pos, pos_vld, err, lost} !== {8'h00, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_async: pos=%02h vld=%0b err=%0b lost=%0b, expected 00 0 0 1", pos, pos_vld, err, lost);
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({pos, pos_vld, err, lost} !== {8'h00, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_held: pos=%02h vld=%0b err=%0b lost=%0b, expected 00 0 0 1", pos, pos_vld, err, lost);
        end
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if ({pos, pos_vld, err, lost} !== {8'h00, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_release: pos=%02h vld=%0b err=%0b lost=%0b, expected 00 0 0 1", pos, pos_vld, err, lost);
        end
    endtask

    task automatic test_width_sweep();
        obs_q.delete(); exp_q.delete();
        pulse(T_MIN, 10);
        pulse(T_MIN + 128 * T_STEP, 10);
        pulse(T_MIN + 255 * T_STEP, 10);
        pulse(650, 10);
        pulse(70, 10);
        repeat (10) @(negedge clk);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL sweep_count: observed %0d events, expected %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL sweep_ev%0d: observed vld=%0b cyc=%0d pos=%02h lost=%0b, expected vld=%0b cyc=%0d pos=%02h lost=%0b",
                         i, obs_q[i].vld, obs_q[i].cyc, obs_q[i].pos, obs_q[i].lost,
                         exp_q[i].vld, exp_q[i].cyc, exp_q[i].pos, exp_q[i].lost);
            end
        end
    endtask

    task automatic test_glitch_bounds();
        obs_q.delete(); exp_q.delete();
        pulse(T_MIN + 128 * T_STEP, 10);
        pulse(20, 10);
        pulse(T_GLITCH - 1, 10);
        pulse(T_GLITCH, 10);
        pulse(T_MAXP, 10);
        pulse(T_MAXP + 1, 10);
        repeat (10) @(negedge clk);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL glitch_count: observed %0d events, expected %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL glitch_ev%0d: observed vld=%0b cyc=%0d pos=%02h lost=%0b, expected vld=%0b cyc=%0d pos=%02h lost=%0b",
                         i, obs_q[i].vld, obs_q[i].cyc, obs_q[i].pos, obs_q[i].lost,
                         exp_q[i].vld, exp_q[i].cyc, exp_q[i].pos, exp_q[i].lost);
            end
        end
    endtask

    task automatic test_stuck_high();
        obs_q.delete(); exp_q.delete();
        pulse(800, 20);
        pulse(T_MIN + 128 * T_STEP, 10);
        repeat (10) @(negedge clk);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL stuck_count: observed %0d events, expected %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL stuck_ev%0d: observed vld=%0b cyc=%0d pos=%02h lost=%0b, expected vld=%0b cyc=%0d pos=%02h lost=%0b",
                         i, obs_q[i].vld, obs_q[i].cyc, obs_q[i].pos, obs_q[i].lost,
                         exp_q[i].vld, exp_q[i].cyc, exp_q[i].pos, exp_q[i].lost);
            end
        end
    endtask

    task automatic test_async_reset();
        obs_q.delete(); exp_q.delete();
        pulse(T_MIN + 128 * T_STEP, 10);
        repeat (5) @(negedge clk);
        obs_q.delete(); exp_q.delete();
        @(negedge clk);
        srv_i = 1'b1;
        repeat (30) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({pos, pos_vld, err, lost} !== {8'h00, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL async_reset: pos=%02h vld=%0b err=%0b lost=%0b, expected 00 0 0 1", pos, pos_vld, err, lost);
        end
        m_pos = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        srv_i = 1'b0;
        repeat (20) @(negedge clk);
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL partial_ignored: observed %0d events, expected 0", obs_q.size());
        end
        checks++;
        if (lost !== 1'b1) begin
            errors++;
            $display("FAIL lost_after_reset: lost=%0b, expected 1", lost);
        end
        obs_q.delete();
        pulse(T_MIN + 255 * T_STEP + 5, 10);
        repeat (10) @(negedge clk);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL async_count: observed %0d events, expected %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL async_ev%0d: observed vld=%0b cyc=%0d pos=%02h lost=%0b, expected vld=%0b cyc=%0d pos=%02h lost=%0b",
                         i, obs_q[i].vld, obs_q[i].cyc, obs_q[i].pos, obs_q[i].lost,
                         exp_q[i].vld, exp_q[i].cyc, exp_q[i].pos, exp_q[i].lost);
            end
        end
    endtask

    task automatic test_loss();
        int vcyc;
        int first;
        obs_q.delete(); exp_q.delete();
        pulse(T_MIN + 128 * T_STEP, 2);
        vcyc  = int'(exp_q[$].cyc);
        first = -1;
        while (cyc < vcyc + T_LOST + 5) begin
            @(negedge clk);
            if (cyc == vcyc) begin
                checks++;
                if (lost !== 1'b0) begin
                    errors++;
                    $display("FAIL loss_clear: lost=%0b at pos_vld cycle, expected 0", lost);
                end
            end
            if (lost === 1'b1 && cyc > vcyc && first < 0) first = cyc;
        end
        checks++;
        if (first != vcyc + T_LOST) begin
            errors++;
            $display("FAIL loss_timing: lost rose at cycle %0d, expected %0d", first, vcyc + T_LOST);
        end
        pulse(T_MIN + 40 * T_STEP + 1, 10);
        repeat (10) @(negedge clk);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL loss_count: observed %0d events, expected %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL loss_ev%0d: observed vld=%0b cyc=%0d pos=%02h lost=%0b, expected vld=%0b cyc=%0d pos=%02h lost=%0b",
                         i, obs_q[i].vld, obs_q[i].cyc, obs_q[i].pos, obs_q[i].lost,
                         exp_q[i].vld, exp_q[i].cyc, exp_q[i].pos, exp_q[i].lost);
            end
        end
    endtask

    task automatic test_back_to_back();
        obs_q.delete(); exp_q.delete();
        pulse(200, 1);
        pulse(300, 1);
        pulse(T_MAXP + 1, 1);
        pulse(120, 1);
        pulse(30, 1);
        pulse(800, 1);
        for (int k = 0; k < 25; k++) begin
            pulse(int'($urandom_range(30, 760)), int'($urandom_range(1, 4)));
        end
        repeat (12) @(negedge clk);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL b2b_count: observed %0d events, expected %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL b2b_ev%0d: observed vld=%0b cyc=%0d pos=%02h lost=%0b, expected vld=%0b cyc=%0d pos=%02h lost=%0b",
                         i, obs_q[i].vld, obs_q[i].cyc, obs_q[i].pos, obs_q[i].lost,
                         exp_q[i].vld, exp_q[i].cyc, exp_q[i].pos, exp_q[i].lost);
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_width_sweep();
        test_glitch_bounds();
        test_stuck_high();
        test_async_reset();
        test_loss();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/servo_pwm_rx.md
# servo_pwm_rx

Measures the high time of an incoming hobby-servo/RC PWM pulse train and converts it to the same 8-bit position code the servo driver consumes. Sits at a servo-signal input pin, either a receiver channel or a loop-back of the driver output. Produces a registered position with a one-cycle valid strobe, a malformed-pulse error strobe and a sticky loss-of-signal flag. Pin synchronisation is internal; the block is the decode end of the servo PWM interface.

## Interface
- T_MIN, 12000: high time (cycles) mapping to position 0x00.
- T_STEP, 47: cycles per position LSB above T_MIN.
- T_GLITCH, 6000: high pulses shorter than this are rejected.
- T_MAXP, 36000: high pulses longer than this are rejected.
- T_LOST, 480000: cycles without a valid pulse before loss of signal is flagged.
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- srv_i  in  1  raw servo PWM input, asynchronous to clk.
- pos  out  8  last valid decoded position.
- pos_vld  out  1  one-cycle strobe; pos updated this cycle.
- err  out  1  one-cycle strobe; malformed pulse rejected.
- lost  out  1  no valid pulse for T_LOST cycles; sticky until next valid pulse.

## Operation
- srv_i passes through a 2-FF synchroniser and then an edge-detect register. "Level" means the synchronised value. A rise is level 1 with previous 0; a fall is level 0 with previous 1.
- All counters are 20 bits and saturate; none wraps.
- FSM ARM (reset state): waits for level 0, then goes to IDLE. This discards a partial pulse present at reset release or after a rejection.
- FSM IDLE: on a rise, clears the width counter h to 1 and goes to HIGH.
- FSM HIGH: increments h every cycle while level is 1.
  - If h would exceed T_MAXP, pulse err and go to ARM. No pos update occurs on the later fall.
  - On a fall with h < T_GLITCH, pulse err and go to IDLE.
  - On a fall with T_GLITCH ≤ h ≤ T_MAXP, load pos, pulse pos_vld and go to IDLE.
- h is the number of cycles the level was sampled 1.
- Position mapping: pos = 0 if h < T_MIN, else min(255, floor((h − T_MIN)/T_STEP)).
  - Computed during the pulse with a T_STEP prescaler and an 8-bit step counter that saturates at 255. No divider.
- Loss counter increments every cycle and saturates at T_LOST.
  - It is cleared on pos_vld.
  - When it reaches T_LOST, lost is set to 1.
  - pos_vld clears lost in the same cycle.
- Reset values: pos = 0x00, pos_vld = 0, err = 0, lost = 1, FSM = ARM, synchroniser = 0, all counters = 0.
- Asynchronous reset mid-pulse aborts the measurement. After release, the block re-enters ARM and ignores the remainder of that pulse.

## Timing
- Synchroniser delay is 2 cycles. The edge is detected on the 3rd clk edge after srv_i changes, counting the sampling edge as the 1st.
- pos, pos_vld and err are registered outputs. pos_vld or err asserts in the cycle after the fall is detected, 3 cycles after srv_i falls.
- pos holds its value between strobes. pos_vld and err never assert together, and each is exactly 1 cycle wide.
- The T_MAXP err asserts in the cycle after h reaches T_MAXP + 1, independent of srv_i.
- lost rises exactly T_LOST cycles after the last pos_vld, or after reset release if no pulse arrives.
- A rise arriving in the same cycle as a pos_vld/err return to IDLE is not lost. The IDLE transition is taken first and the rise detection is held one cycle; h stays exact.
- Back-to-back pulses with a 1-cycle low gap are decoded correctly.

## Test plan
- Width sweep of exactly h high cycles:
  - h = 12000 → pos 0x00.
  - h = 18016 → pos 0x80.
  - h = 24000 → pos 0xFF.
  - h = 30000 → pos 0xFF (saturated).
  - h = 8000 → pos 0x00.
  - Each gives one pos_vld, 3 cycles after the fall.
- Glitch: after a valid pulse with pos 0x80, a 100-cycle pulse → err 1 cycle, pos stays 0x80, no pos_vld.
- Stuck high: srv_i high for 40000 cycles → err 36004 cycles after the rise; no pos_vld on the fall; the next 18016-cycle pulse → pos 0x80.
- Reset released while srv_i high → that pulse is ignored (no pos_vld, no err); the next 24000-cycle pulse → pos 0xFF, lost drops to 0 with it.
- Loss: valid pulse, then srv_i held low → lost = 1 exactly 480000 cycles after pos_vld; the next valid pulse clears lost in its pos_vld cycle.
- rst_n asserted mid-pulse → all outputs at reset values immediately, without a clock.
